// File: rtl/dpmem_fifo_ctrl_if.sv
// Producer/consumer stream bundle for dpmem_fifo_ctrl.
// slave is the controller side; master is the producer/consumer side.
interface dpmem_fifo_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/dpmem_fifo_ctrl.sv
// FIFO controller for an external read-first dual-port RAM.
// Port A writes, port B reads; a small prefetch buffer hides the
// RAM read latency (1 + OUTREG) so the consumer sees a plain stream.
module dpmem_fifo_ctrl #(
    parameter int DEPTH  = 10,
    parameter int WIDTH  = 32,
    parameter int OUTREG = 0
) (
    input  logic               clk,
    input  logic               srst,
    dpmem_fifo_ctrl_if.slave   s,
    output logic [DEPTH+1:0]   level,
    output logic               mem_ena,
    output logic               mem_wea,
    output logic [DEPTH-1:0]   mem_addra,
    output logic [WIDTH-1:0]   mem_dia,
    output logic               mem_enb,
    output logic               mem_web,
    output logic [DEPTH-1:0]   mem_addrb,
    input  logic [WIDTH-1:0]   mem_dob
);

    localparam int L  = 1 + OUTREG;       // RAM read latency
    localparam int NB = L + 1;            // prefetch buffer entries
    localparam int BW = $clog2(NB);       // buffer pointer width
    localparam int CW = $clog2(NB + 1);   // buffer / in-flight count width

    logic             push, pop, issue, capture;
    logic [DEPTH-1:0] wptr, rptr;
    logic [DEPTH:0]   ram_count, ram_count_nxt;
    logic [L-1:0]     tag_pipe;
    logic [CW-1:0]    inflight;
    logic [CW:0]      occ;
    logic [WIDTH-1:0] pf_mem [NB];
    logic [BW-1:0]    head, tail, head_nxt;
    logic [CW-1:0]    buf_count, buf_count_nxt;
    logic             wr_ready_q, rd_valid_q, enb_q;
    logic [WIDTH-1:0] rd_data_q, rd_data_nxt;
    logic [DEPTH+1:0] level_nxt;

    function automatic logic [BW-1:0] inc_b(input logic [BW-1:0] p);
        return (p == BW'(NB - 1)) ? '0 : p + BW'(1);
    endfunction

    // srst gates the strobes so nothing reaches the RAM during reset
    assign push    = s.wr_valid & wr_ready_q & ~srst;
    assign pop     = rd_valid_q & s.rd_ready;
    assign capture = tag_pipe[L-1];

    assign mem_ena   = push;
    assign mem_wea   = push;
    assign mem_addra = wptr;
    assign mem_dia   = s.wr_data;
    assign mem_enb   = enb_q & ~srst;
    assign mem_web   = 1'b0;
    assign mem_addrb = rptr;

    assign s.wr_ready = wr_ready_q;
    assign s.rd_valid = rd_valid_q;
    assign s.rd_data  = rd_data_q;

    // Read issue: a slot is reserved in the buffer for every in-flight read.
    // A pop frees its slot on the same edge, so counting it keeps a
    // continuous drain free of bubbles.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < L; i++) inflight = inflight + CW'(tag_pipe[i]);
        occ   = {1'b0, buf_count} + {1'b0, inflight} - (CW+1)'(pop);
        issue = (ram_count != '0) && (occ < (CW+1)'(NB));
    end

    // Next-state counts, buffer head and the registered output word
    always_comb begin
        ram_count_nxt = ram_count + (DEPTH+1)'(push) - (DEPTH+1)'(issue);
        buf_count_nxt = buf_count + CW'(capture) - CW'(pop);
        level_nxt     = level + (DEPTH+2)'(push) - (DEPTH+2)'(pop);
        head_nxt      = pop ? inc_b(head) : head;
        // Buffer drained this edge while a word lands: present the RAM data directly
        if (capture && (buf_count == CW'(pop)))
            rd_data_nxt = mem_dob;
        else
            rd_data_nxt = pf_mem[head_nxt];
    end

    // Control state: pointers, counts, tag pipe and handshake flags
    always_ff @(posedge clk) begin
        if (srst) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_count  <= '0;
            tag_pipe   <= '0;
            head       <= '0;
            tail       <= '0;
            buf_count  <= '0;
            level      <= '0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            enb_q      <= 1'b0;
        end else begin
            if (push)    wptr <= wptr + DEPTH'(1);
            if (issue)   rptr <= rptr + DEPTH'(1);
            if (capture) tail <= inc_b(tail);
            tag_pipe[0] <= issue;
            for (int i = 1; i < L; i++) tag_pipe[i] <= tag_pipe[i-1];
            ram_count  <= ram_count_nxt;
            buf_count  <= buf_count_nxt;
            head       <= head_nxt;
            level      <= level_nxt;
            // ram_count never exceeds 2**DEPTH, so its MSB alone flags full
            wr_ready_q <= ~ram_count_nxt[DEPTH];
            rd_valid_q <= (buf_count_nxt != '0);
            enb_q      <= 1'b1;
        end
    end

    // Prefetch storage and output data register (no reset: qualified by valids)
    always_ff @(posedge clk) begin
        if (capture) pf_mem[tail] <= mem_dob;
        rd_data_q <= rd_data_nxt;
    end

endmodule

// File: tb/tb_dpmem_fifo_ctrl.sv
// Bench for dpmem_fifo_ctrl: two instances (OUTREG=0 and 1, DEPTH=4)
// driven by the same stimulus, each with a read-first RAM model and its
// own scoreboard queue.
module tb_dpmem_fifo_ctrl;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    dpmem_fifo_ctrl_if #(.WIDTH(32)) b0 ();
    dpmem_fifo_ctrl_if #(.WIDTH(32)) b1 ();

    logic [5:0]  level0, level1;
    logic        ena0, wea0, enb0, web0, ena1, wea1, enb1, web1;
    logic [3:0]  addra0, addrb0, addra1, addrb1;
    logic [31:0] dia0, dob0, dia1, dob1_r, dob1;

    dpmem_fifo_ctrl #(.DEPTH(4), .WIDTH(32), .OUTREG(0)) u0 (
        .clk(clk), .srst(srst), .s(b0.slave), .level(level0),
        .mem_ena(ena0), .mem_wea(wea0), .mem_addra(addra0), .mem_dia(dia0),
        .mem_enb(enb0), .mem_web(web0), .mem_addrb(addrb0), .mem_dob(dob0)
    );

    dpmem_fifo_ctrl #(.DEPTH(4), .WIDTH(32), .OUTREG(1)) u1 (
        .clk(clk), .srst(srst), .s(b1.slave), .level(level1),
        .mem_ena(ena1), .mem_wea(wea1), .mem_addra(addra1), .mem_dia(dia1),
        .mem_enb(enb1), .mem_web(web1), .mem_addrb(addrb1), .mem_dob(dob1)
    );

    // Read-first dual-port RAM models
    logic [31:0] ram0 [16];
    logic [31:0] ram1 [16];
    always @(posedge clk) begin
        if (ena0 && wea0) ram0[addra0] <= dia0;
        if (enb0) dob0 <= ram0[addrb0];
        if (ena1 && wea1) ram1[addra1] <= dia1;
        if (enb1) dob1_r <= ram1[addrb1];
        dob1 <= dob1_r;
    end

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          model [2];
    int          acc [2];
    int          pops [2];
    int          first_pop [2];
    int          last_pop [2];
    logic [31:0] last_data [2];
    logic        stalled [2];
    logic [31:0] held [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0; pops[i] = 0; first_pop[i] = -1; last_pop[i] = -1;
        end
    endtask

    // Observe one instance in the middle of a cycle: scoreboard push/pop,
    // level against the accepted-minus-delivered count, stall stability.
    task automatic obs(input int id, input logic wv, input logic wr, input logic [31:0] wd,
                       input logic rv, input logic rr, input logic [31:0] rd, input logic [5:0] lvl);
        logic [31:0] exp;
        int qs;
        if (srst) begin
            if (id == 0) q0.delete(); else q1.delete();
            model[id] = 0;
            stalled[id] = 1'b0;
            return;
        end
        checks++;
        assert (lvl === 6'(model[id])) else begin
            errors++;
            $error("FAIL level%0d got=%0d want=%0d", id, lvl, model[id]);
        end
        if (stalled[id]) begin
            checks++;
            assert (rv === 1'b1 && rd === held[id]) else begin
                errors++;
                $error("FAIL stall_hold%0d got=%0b/%0h want=1/%0h", id, rv, rd, held[id]);
            end
        end
        if (wv && wr) begin
            if (id == 0) q0.push_back(wd); else q1.push_back(wd);
            acc[id]++;
            model[id]++;
        end
        if (rv && rr) begin
            qs = (id == 0) ? q0.size() : q1.size();
            checks++;
            assert (qs > 0) else begin
                errors++;
                $error("FAIL unexpected_pop%0d got=%0h want=none", id, rd);
            end
            if (qs > 0) begin
                if (id == 0) exp = q0.pop_front(); else exp = q1.pop_front();
                checks++;
                assert (rd === exp) else begin
                    errors++;
                    $error("FAIL rd_data%0d got=%0h want=%0h", id, rd, exp);
                end
            end
            model[id]--;
            pops[id]++;
            if (first_pop[id] < 0) first_pop[id] = ncyc;
            last_pop[id]  = ncyc;
            last_data[id] = rd;
        end
        stalled[id] = rv && !rr;
        held[id]    = rd;
    endtask

    task automatic cyc();
        @(negedge clk);
        obs(0, b0.wr_valid, b0.wr_ready, b0.wr_data, b0.rd_valid, b0.rd_ready, b0.rd_data, level0);
        obs(1, b1.wr_valid, b1.wr_ready, b1.wr_data, b1.rd_valid, b1.rd_ready, b1.rd_data, level1);
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wv, input logic [31:0] wd, input logic rr);
        b0.wr_valid = wv; b0.wr_data = wd; b0.rd_ready = rr;
        b1.wr_valid = wv; b1.wr_data = wd; b1.rd_ready = rr;
    endtask

    task automatic drain(input string tag);
        set_in(1'b0, 32'h0, 1'b1);
        for (int t = 0; t < 80 && (q0.size() != 0 || q1.size() != 0); t++) cyc();
        chk({tag, "_empty0"}, q0.size(), 0);
        chk({tag, "_empty1"}, q1.size(), 0);
    endtask

    task automatic latency(input logic [31:0] d);
        int f0, f1, h0, h1;
        f0 = -1; f1 = -1; h0 = 0; h1 = 0;
        set_in(1'b1, d, 1'b1);
        cyc();
        set_in(1'b0, 32'h0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            if (b0.rd_valid) begin
                h0++;
                if (f0 < 0) begin f0 = k; chk("lat_data0", b0.rd_data, d); end
            end
            if (b1.rd_valid) begin
                h1++;
                if (f1 < 0) begin f1 = k; chk("lat_data1", b1.rd_data, d); end
            end
            cyc();
        end
        chk("lat_cycles0", f0, 3);
        chk("lat_cycles1", f1, 4);
        chk("lat_width0", h0, 1);
        chk("lat_width1", h1, 1);
        chk("lat_level0", level0, 0);
        chk("lat_level1", level1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_stats();
        for (int i = 0; i < 2; i++) begin model[i] = 0; stalled[i] = 1'b0; held[i] = '0; end

        // Reset held with wr_valid asserted
        srst = 1'b1;
        set_in(1'b1, 32'hDEAD0001, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_wr_ready0", b0.wr_ready, 0);
            chk("rst_wr_ready1", b1.wr_ready, 0);
            chk("rst_rd_valid0", b0.rd_valid, 0);
            chk("rst_rd_valid1", b1.rd_valid, 0);
            chk("rst_level0", level0, 0);
            chk("rst_wea0", wea0, 0);
            chk("rst_wea1", wea1, 0);
            chk("rst_enb0", enb0, 0);
        end
        srst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0);
        cyc();
        chk("rel_wr_ready0", b0.wr_ready, 1);
        chk("rel_wr_ready1", b1.wr_ready, 1);
        chk("rel_enb0", enb0, 1);
        chk("rel_enb1", enb1, 1);
        chk("rel_web0", web0, 0);
        chk("rel_web1", web1, 0);
        chk("rel_level0", level0, 0);
        chk("rel_level1", level1, 0);

        // Single-word latency, two data patterns
        latency(32'h11223344);
        latency(32'h55667788);

        // Fill with consumer stalled, then drain
        clr_stats();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 32'(i), 1'b0);
            cyc();
        end
        set_in(1'b0, 32'h0, 1'b0);
        repeat (4) cyc();
        chk("fill_acc0", acc[0], 18);
        chk("fill_acc1", acc[1], 19);
        chk("fill_level0", level0, 18);
        chk("fill_level1", level1, 19);
        chk("fill_wr_ready0", b0.wr_ready, 0);
        chk("fill_wr_ready1", b1.wr_ready, 0);
        chk("fill_rd_valid0", b0.rd_valid, 1);
        drain("fill");
        chk("fill_pops0", pops[0], 18);
        chk("fill_pops1", pops[1], 19);
        chk("fill_gapless0", last_pop[0] - first_pop[0], 17);
        chk("fill_gapless1", last_pop[1] - first_pop[1], 18);
        chk("fill_last0", last_data[0], 17);
        chk("fill_last1", last_data[1], 18);
        cyc();
        chk("fill_done_valid0", b0.rd_valid, 0);
        chk("fill_done_level1", level1, 0);

        // Continuous stream with rd_ready pattern 1,0,0,1
        clr_stats();
        for (int i = 0; i < 80; i++) begin
            set_in(1'b1, 32'hA5000000 + 32'(i), (i % 4 == 0) || (i % 4 == 3));
            cyc();
        end
        drain("stream");
        chk("stream_count0", pops[0], acc[0]);
        chk("stream_count1", pops[1], acc[1]);
        chk("stream_level0", level0, 0);

        // Reset in the middle of operation
        clr_stats();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'hB0 + 32'(i), 1'b0);
            cyc();
        end
        set_in(1'b0, 32'h0, 1'b0);
        repeat (3) cyc();
        chk("mid_level0", level0, 10);
        chk("mid_level1", level1, 10);
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        chk("mid_rst_level0", level0, 0);
        chk("mid_rst_level1", level1, 0);
        chk("mid_rst_valid0", b0.rd_valid, 0);
        chk("mid_rst_valid1", b1.rd_valid, 0);
        clr_stats();
        set_in(1'b1, 32'hCAFEDECA, 1'b1);
        for (int t = 0; t < 6 && acc[0] == 0; t++) cyc();
        set_in(1'b0, 32'h0, 1'b1);
        for (int t = 0; t < 10 && (pops[0] == 0 || pops[1] == 0); t++) cyc();
        chk("mid_acc0", acc[0], 1);
        chk("mid_acc1", acc[1], 1);
        chk("mid_first0", last_data[0], 32'hCAFEDECA);
        chk("mid_first1", last_data[1], 32'hCAFEDECA);
        repeat (3) cyc();
        chk("mid_pops0", pops[0], 1);
        chk("mid_pops1", pops[1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dpmem_fifo_ctrl.md
Name: dpmem_fifo_ctrl

Overview:
Single-clock FIFO controller that drives an external read-first dual-port RAM (dpmemrf).
- Port A is used for writes only; port B is used for reads only.
- Absorbs the RAM read latency (1 + OUTREG cycles) with a prefetch buffer.
- Presents valid/ready streams on both the producer and consumer sides.
- Sits between a stream producer and the RAM macro; all RAM storage stays in dpmemrf.

Parameters:
DEPTH, 10, RAM address width; RAM holds 2**DEPTH words.
WIDTH, 32, data width.
OUTREG, 0, must match the RAM's port-B OUTREGB (0 or 1); read latency L = 1 + OUTREG.

Ports:
clk  in  1  single clock; both RAM clocks are driven from it externally.
srst  in  1  synchronous reset, active-high.
wr_valid  in  1  producer word valid.
wr_ready  out  1  controller accepts the word.
wr_data  in  WIDTH  producer data.
rd_valid  out  1  output word valid.
rd_ready  in  1  consumer accepts the word.
rd_data  out  WIDTH  output data.
level  out  DEPTH+2  total words held (RAM + in-flight + buffer).
mem_ena  out  1  RAM port-A enable.
mem_wea  out  1  RAM port-A write enable.
mem_addra  out  DEPTH  RAM port-A address.
mem_dia  out  WIDTH  RAM port-A write data.
mem_enb  out  1  RAM port-B enable.
mem_web  out  1  RAM port-B write enable, tied 0.
mem_addrb  out  DEPTH  RAM port-B address.
mem_dob  in  WIDTH  RAM port-B read data.

Behaviour:
Reset:
- Clock is clk; reset srst is synchronous and active-high.
- On srst: wptr, rptr, ram_count, in-flight tags, buffer count and level all = 0.
- On srst: wr_ready = 0, rd_valid = 0, mem_ena = mem_wea = mem_enb = 0, addresses = 0.
- rd_data is don't-care while rd_valid = 0.
- First cycle after reset release: wr_ready = 1, mem_enb = 1.

Write side:
- wr_ready = (ram_count < 2**DEPTH), registered.
- Push on wr_valid & wr_ready: same cycle, drive mem_ena = mem_wea = 1, mem_addra = wptr, mem_dia = wr_data.
- After a push, wptr increments and wraps mod 2**DEPTH.
- When not pushing, mem_ena = mem_wea = 0.

Read side:
- mem_enb stays 1 continuously after reset; mem_addrb = rptr.
- Issue condition: ram_count > 0 and (buf_count + inflight) < L+1.
- On issue: rptr increments (wraps mod 2**DEPTH), ram_count decrements, and a valid tag enters a shift pipe L deep.
- When the tag exits the pipe, mem_dob is captured into the prefetch buffer (L+1 entries, circular).
- rd_valid = (buf_count > 0); rd_data = buffer head, registered.
- Pop on rd_valid & rd_ready.
- rd_data/rd_valid hold stable while rd_valid & ~rd_ready.

Latency:
- Word pushed into an empty controller at edge E is issued in cycle E+1.
- It is captured at edge E+1+L.
- rd_valid = 1 from cycle E+2+L, i.e. 3 + OUTREG cycles after the push edge.

Capacity:
- 2**DEPTH + L + 1 words.
- level = ram_count + inflight + buf_count, updated the cycle after each push, issue or pop.
- Simultaneous push and pop leaves level unchanged.

Collisions:
- Port A writes only free slots; port B reads only occupied slots.
- Same-cycle same-address access is impossible, so no bypass is required.

Boundary conditions:
- Push while RAM full is ignored (wr_ready = 0).
- Pop with buffer empty is ignored.
- Pointer wrap is silent.
- srst mid-operation discards all contents, including in-flight reads; no partial word is ever delivered.

Test Plan:
1. Reset: hold srst 3 cycles with wr_valid = 1 -> wr_ready = 0, rd_valid = 0, level = 0, mem_wea = 0. After release: wr_ready = 1, level = 0.
2. Latency (DEPTH=4, OUTREG=0): push 32'h11223344 once with rd_ready = 1 -> rd_valid rises exactly 3 cycles after the push edge with rd_data = 32'h11223344 for one cycle; level returns to 0.
3. Latency (OUTREG=1): same stimulus with 32'h55667788 -> rd_valid rises 4 cycles after the push edge with correct data.
4. Fill (DEPTH=4, OUTREG=0), rd_ready = 0: push words 0..19 -> exactly 18 words accepted; wr_ready = 0; level = 18. Then drain with rd_ready = 1 -> values 0..17 out in order with no gaps after the first, wrapping pointers.
5. Stream with backpressure: continuous pushes of an incrementing pattern, rd_ready toggling 1,0,0,1 -> output sequence strictly in order with no loss or duplication; rd_data stable during stalls; level stays within [0, 18].
6. Reset mid-operation: with 10 words held, pulse srst 1 cycle -> next cycle level = 0, rd_valid = 0. A following push of 32'hCAFEDECA is the first word read out.
